piso_serializer: RTL and testbench
==================================

Name:
piso_serializer

Overview:
- Parallel-in, serial-out shift register that converts a WIDTH-bit word into a timed serial bit stream.
- Feeds the transmit path (tx line) of the RS232 transmitter.
- A word is captured on a load request; its bits are then driven one at a time, each held for CLKS_PER_BIT clocks.
- Status outputs report when the block is busy and when a word has finished.

Parameters:
- WIDTH, 8: parallel word width in bits (1..32).
- CLKS_PER_BIT, 1: clock cycles each bit is held on serial_out (1..65535).
- LSB_FIRST, 1: 1 = bit 0 is sent first; 0 = bit WIDTH-1 is sent first.
- IDLE_LEVEL, 1'b0: value of serial_out while idle and during reset.

Ports:
- clk  input  1  system clock; all logic updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data  input  WIDTH  parallel word; sampled only on an accepted load.
- load  input  1  load request; accepted on a rising edge where load=1 and busy=0.
- serial_out  output  1  serial bit stream.
- busy  output  1  high while a word is being shifted out.
- done  output  1  one-cycle pulse when the last bit period of a word ends.

Behaviour:
- Reset (rst=1 at a rising edge) forces, from that edge on:
  - serial_out=IDLE_LEVEL, busy=0, done=0;
  - shift register and all counters cleared.
- Reset overrides everything, including a load in the same cycle.
- Reset during a transfer aborts it immediately; no done pulse is produced.
- States:
  - IDLE: busy=0, serial_out=IDLE_LEVEL.
  - SHIFT: busy=1.
- IDLE -> SHIFT on an accepted load at edge N. After edge N:
  - data has been captured into the shift register;
  - serial_out = first bit (data[0] if LSB_FIRST, else data[WIDTH-1]);
  - busy=1;
  - the bit-cycle counter starts at 0.
- In SHIFT, each bit is held for exactly CLKS_PER_BIT cycles, then the next bit is presented.
- Bit k (k=0..WIDTH-1) is on serial_out after edges N+k*CLKS_PER_BIT through N+(k+1)*CLKS_PER_BIT-1.
- At edge N+WIDTH*CLKS_PER_BIT:
  - state returns to IDLE, busy=0, serial_out=IDLE_LEVEL;
  - done=1 for exactly one cycle.
- Total latency: load accepted to done rising = WIDTH*CLKS_PER_BIT cycles.
- load while busy=1 is ignored; the word in flight is unaffected.
- Changing data while busy has no effect.
- Back-to-back transfers:
  - busy=0 in the done cycle, so a load sampled at edge N+WIDTH*CLKS_PER_BIT is accepted;
  - in that case the first bit of the new word replaces IDLE_LEVEL immediately, with no idle gap;
  - busy stays 1 and done still pulses for the finished word.
- load held continuously high therefore produces gapless repeated frames.
- Counters:
  - bit index counter is ceil(log2(WIDTH+1)) bits wide;
  - cycle counter is ceil(log2(CLKS_PER_BIT+1)) bits wide;
  - neither counter ever wraps mid-frame.
- serial_out, busy and done are registered outputs with no combinational path from any input.

Decomposition:
- No shared package is required.
- If a package is used, it holds only the state enumeration (IDLE, SHIFT) and a clog2 helper.
- One natural sub-module, piso_bit_timer: counts CLKS_PER_BIT cycles and emits a one-cycle bit_tick.
- The shift register and state machine stay in piso_serializer.

Test Plan:
- Reset with load=1 and data=8'hFF → serial_out=0, busy=0, done=0 on every edge while rst=1; no transfer starts after reset is released.
- Defaults (WIDTH=8, CLKS_PER_BIT=1, LSB_FIRST=1), data=8'hA5, load pulsed one cycle → serial_out = 1,0,1,0,0,1,0,1 over 8 cycles, busy=1 for those 8 cycles, done=1 in cycle 9 with busy=0.
- CLKS_PER_BIT=4, LSB_FIRST=0, data=8'h81 → serial_out=1 for 4 cycles, 0 for 24 cycles, 1 for 4 cycles; done exactly 32 cycles after load acceptance.
- load re-pulsed with data=8'h00 mid-transfer of 8'hFF → output stays eight 1s; second load ignored; single done pulse.
- load held high with data=8'h3C then 8'hC3 → two frames back-to-back, no idle cycle between them, busy stays 1 across the boundary, two done pulses 8 cycles apart.
- rst asserted after bit 3 of 8'hF0 → serial_out=0 and busy=0 from the next edge; no done pulse; a new load afterwards transmits correctly from bit 0.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// rtl/piso_serializer_pkg.sv - state enumeration and width helper for the serializer
package piso_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Smallest r with 2**r >= v; used to size the bit-index and cycle counters.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/piso_bit_timer.sv
// rtl/piso_bit_timer.sv - counts CLKS_PER_BIT cycles per bit and flags the last one
module piso_bit_timer #(
  parameter int CLKS_PER_BIT = 1,
  parameter int CW           = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic bit_tick
);

  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_tick = en && (cnt_q == LAST_CNT);

  // Counter restarts at 0 on a new word and after every tick, so it never wraps.
  always_comb begin
    cnt_d = '0;
    if (!clear && en && !bit_tick) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out shifter with busy/done status
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int   WIDTH        = 8,
  parameter int   CLKS_PER_BIT = 1,
  parameter int   LSB_FIRST    = 1,
  parameter logic IDLE_LEVEL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam int BW = clog2(WIDTH + 1);
  localparam int CW = clog2(CLKS_PER_BIT + 1);
  localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_idx_q, bit_idx_d;
  logic             serial_q, serial_d;
  logic             done_q, done_d;
  logic             bit_tick;
  logic             frame_end;
  logic             start;

  // A load on the final edge of a frame is accepted, giving gapless back-to-back words.
  assign frame_end = (state_q == SHIFT) && bit_tick && (bit_idx_q == LAST_IDX);
  assign start     = load && ((state_q == IDLE) || frame_end);

  piso_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CW          (CW)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (start),
    .en      (state_q == SHIFT),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    serial_d  = serial_q;
    done_d    = frame_end;
    if (start) begin
      state_d   = SHIFT;
      shreg_d   = data;
      bit_idx_d = '0;
      serial_d  = (LSB_FIRST != 0) ? data[0] : data[WIDTH-1];
    end else if (frame_end) begin
      state_d   = IDLE;
      shreg_d   = '0;
      bit_idx_d = '0;
      serial_d  = IDLE_LEVEL;
    end else if ((state_q == SHIFT) && bit_tick) begin
      shreg_d   = (LSB_FIRST != 0) ? (shreg_q >> 1) : (shreg_q << 1);
      bit_idx_d = bit_idx_q + 1'b1;
      serial_d  = (LSB_FIRST != 0) ? shreg_d[0] : shreg_d[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      serial_q  <= IDLE_LEVEL;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      serial_q  <= serial_d;
      done_q    <= done_d;
    end
  end

  assign serial_out = serial_q;
  assign busy       = (state_q == SHIFT);
  assign done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed self-checking bench for piso_serializer
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_a, data_b;
  logic       load_a, load_b;
  logic       ser_a, busy_a, done_a;
  logic       ser_b, busy_b, done_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  piso_serializer dut_a (
    .clk(clk), .rst(rst), .data(data_a), .load(load_a),
    .serial_out(ser_a), .busy(busy_a), .done(done_a)
  );

  piso_serializer #(.WIDTH(8), .CLKS_PER_BIT(4), .LSB_FIRST(0), .IDLE_LEVEL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .data(data_b), .load(load_b),
    .serial_out(ser_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream is given in transmission order: stream[7] is the first bit on the line.
  task automatic expect_frame_a(input string tag, input logic [7:0] stream);
    for (int i = 0; i < 8; i++) begin
      check({tag, "_bit"}, ser_a, stream[7-i]);
      check({tag, "_busy"}, busy_a, 1'b1);
      check({tag, "_done"}, done_a, 1'b0);
      step();
    end
  endtask

  initial begin
    rst = 1'b1; load_a = 1'b1; data_a = 8'hFF; load_b = 1'b1; data_b = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_ser", ser_a, 1'b0);
      check("rst_busy", busy_a, 1'b0);
      check("rst_done", done_a, 1'b0);
      check("rst_busy_b", busy_b, 1'b0);
    end
    rst = 1'b0; load_a = 1'b0; load_b = 1'b0;
    step();
    check("post_rst_busy", busy_a, 1'b0);
    step();
    check("post_rst_busy2", busy_a, 1'b0);
    check("post_rst_ser", ser_a, 1'b0);

    // A5 LSB-first, one clock per bit
    data_a = 8'hA5; load_a = 1'b1;
    step();
    load_a = 1'b0; data_a = 8'h00;
    expect_frame_a("a5", 8'b1010_0101);
    check("a5_end_done", done_a, 1'b1);
    check("a5_end_busy", busy_a, 1'b0);
    check("a5_end_ser", ser_a, 1'b0);
    step();
    check("a5_done_pulse", done_a, 1'b0);

    // 81 MSB-first, four clocks per bit
    data_b = 8'h81; load_b = 1'b1;
    step();
    load_b = 1'b0;
    for (int c = 0; c < 32; c++) begin
      check("b81_ser", ser_b, (c < 4 || c >= 28) ? 1'b1 : 1'b0);
      check("b81_busy", busy_b, 1'b1);
      check("b81_done", done_b, 1'b0);
      step();
    end
    check("b81_done_at_32", done_b, 1'b1);
    check("b81_idle_busy", busy_b, 1'b0);
    check("b81_idle_ser", ser_b, 1'b0);
    step();

    // Second load mid-transfer is ignored
    data_a = 8'hFF; load_a = 1'b1;
    step();
    load_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("ign_bit", ser_a, 1'b1);
      check("ign_busy", busy_a, 1'b1);
      check("ign_done", done_a, 1'b0);
      if (i == 3) begin
        data_a = 8'h00; load_a = 1'b1;
      end else begin
        load_a = 1'b0;
      end
      step();
    end
    check("ign_end_done", done_a, 1'b1);
    check("ign_end_busy", busy_a, 1'b0);
    step();
    check("ign_single_done", done_a, 1'b0);
    check("ign_no_restart", busy_a, 1'b0);

    // Load held high: 3C then C3 with no gap
    data_a = 8'h3C; load_a = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      check("b2b1_bit", ser_a, (8'b0011_1100 >> (7 - i)) & 1);
      check("b2b1_busy", busy_a, 1'b1);
      check("b2b1_done", done_a, 1'b0);
      if (i == 7) data_a = 8'hC3;
      step();
    end
    for (int i = 0; i < 8; i++) begin
      check("b2b2_bit", ser_a, (8'b1100_0011 >> (7 - i)) & 1);
      check("b2b2_busy", busy_a, 1'b1);
      check("b2b2_done", done_a, (i == 0) ? 1'b1 : 1'b0);
      load_a = 1'b0;
      step();
    end
    check("b2b_end_done", done_a, 1'b1);
    check("b2b_end_busy", busy_a, 1'b0);
    step();

    // Reset mid-frame of F0 after bit 3
    data_a = 8'hF0; load_a = 1'b1;
    step();
    load_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("abort_bit", ser_a, 1'b0);
      check("abort_busy", busy_a, 1'b1);
      step();
    end
    check("abort_bit4", ser_a, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_ser", ser_a, 1'b0);
    check("abort_busy_clr", busy_a, 1'b0);
    check("abort_done", done_a, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("abort_no_done", done_a, 1'b0);
      check("abort_idle", busy_a, 1'b0);
    end
    data_a = 8'hA5; load_a = 1'b1;
    step();
    load_a = 1'b0;
    expect_frame_a("relo", 8'b1010_0101);
    check("relo_done", done_a, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
